// File: rtl/fixed_point_mac_accumulator.sv
// Fixed-point MAC accumulator: sums N_ACC signed products in a guard-extended
// accumulator, rounds to OUT_FRAC fractional bits, saturates to OUT_W bits and
// offers the result on a valid/ready handshake.
// Build option: define FXP_MAC_CONVERGENT_ROUND_EN for round-half-to-even;
// otherwise rounding is half-up.
module fixed_point_mac_accumulator #(
  parameter int unsigned PROD_W    = 35,
  parameter int unsigned PROD_FRAC = 26,
  parameter int unsigned ACC_GUARD = 8,
  parameter int unsigned N_ACC     = 16,
  parameter int unsigned OUT_W     = 18,
  parameter int unsigned OUT_FRAC  = 14,
  localparam int unsigned CNT_W    = $clog2(N_ACC + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [PROD_W-1:0] product_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [OUT_W-1:0]  result_o,
  output logic                     saturated_o,
  output logic [CNT_W-1:0]         count_o
);

  localparam int unsigned AccW = PROD_W + ACC_GUARD;
  localparam int unsigned RndW = AccW + 1;
  localparam int unsigned SH   = PROD_FRAC - OUT_FRAC;

  localparam logic [CNT_W-1:0]       CountLastM1 = CNT_W'(N_ACC - 1);
  localparam logic signed [RndW-1:0] Half        = RndW'(1) << (SH - 1);
  localparam logic signed [RndW-1:0] OutMax      = RndW'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [RndW-1:0] OutMin      = ~OutMax;

  typedef enum logic [1:0] {StAccum, StRound, StHold} state_e;

  state_e                  state_q, state_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic signed [OUT_W-1:0] result_q, result_d;
  logic                    sat_q, sat_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic                    beat;
  logic signed [AccW-1:0]  prod_ext;
  logic signed [RndW-1:0]  acc_ext, bias, sum, rounded;
  logic signed [OUT_W-1:0] rnd_result;
  logic                    rnd_sat;

  // in_ready_q is only ever set while in StAccum, so it alone qualifies a beat.
  assign beat     = in_valid_i && in_ready_q;
  assign prod_ext = {{ACC_GUARD{product_i[PROD_W-1]}}, product_i};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StAccum;
    end else begin
      case (state_q)
        StAccum: if (beat && (count_q == CountLastM1)) state_d = StRound;
        StRound: state_d = StHold;
        StHold:  if (out_ready_i) state_d = StAccum;
        default: state_d = StAccum;
      endcase
    end
  end

  // Round the accumulator one bit wider than itself so the bias add cannot wrap.
  always_comb begin
    acc_ext = {acc_q[AccW-1], acc_q};
`ifdef FXP_MAC_CONVERGENT_ROUND_EN
    // On an exact tie with an even kept LSB, bias just below half so it rounds down.
    if ((acc_q[SH-1:0] == Half[SH-1:0]) && !acc_q[SH]) begin
      bias = Half - RndW'(1);
    end else begin
      bias = Half;
    end
`else
    bias = Half;
`endif
    sum     = acc_ext + bias;
    rounded = sum >>> SH;
    if (rounded > OutMax) begin
      rnd_result = OutMax[OUT_W-1:0];
      rnd_sat    = 1'b1;
    end else if (rounded < OutMin) begin
      rnd_result = OutMin[OUT_W-1:0];
      rnd_sat    = 1'b1;
    end else begin
      rnd_result = rounded[OUT_W-1:0];
      rnd_sat    = 1'b0;
    end
  end

  // Datapath next-state: accumulate, capture rounded result, restart after handshake.
  always_comb begin
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    sat_d    = sat_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        StAccum: begin
          if (beat) begin
            acc_d   = acc_q + prod_ext;
            count_d = count_q + CNT_W'(1);
          end
        end
        StRound: begin
          result_d = rnd_result;
          sat_d    = rnd_sat;
        end
        StHold: begin
          if (out_ready_i) begin
            acc_d   = '0;
            count_d = '0;
          end
        end
        default: ;
      endcase
    end
    // Handshake flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == StAccum);
    out_valid_d = (state_d == StHold);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready_o  = in_ready_q;
    out_valid_o = out_valid_q;
    result_o    = result_q;
    saturated_o = sat_q;
    count_o     = count_q;
  end

endmodule

// File: tb/tb_fixed_point_mac_accumulator.sv
// Directed bench for fixed_point_mac_accumulator with hand-computed results.
// Honours FXP_MAC_CONVERGENT_ROUND_EN for the tie-rounding vector.
module tb_fixed_point_mac_accumulator;

  logic               clk;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic signed [34:0] product;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] result;
  logic               saturated;
  logic [4:0]         count;

  int checks = 0;
  int errors = 0;

  fixed_point_mac_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .product_i  (product),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .saturated_o(saturated),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offer n beats of value p; each is consumed on the following rising edge.
  task automatic drive_beats(input int n, input longint p);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      product  = p[34:0];
      @(posedge clk);
    end
  endtask

  // Result is expected in the second cycle after the last beat's edge.
  task automatic wait_valid(input bit hold);
    int n;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 2);
  endtask

  // Check a held result, then confirm the handshake (out_ready=1) empties the block.
  task automatic take(input string tag, input longint exp_res, input longint exp_sat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_sat"}, saturated, exp_sat);
    check({tag, "_in_ready"}, in_ready, 0);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_count0"}, count, 0);
  endtask

  task automatic run(input string tag, input longint p0, input longint rest,
                     input longint exp_res, input longint exp_sat);
    drive_beats(1, p0);
    drive_beats(15, rest);
    wait_valid(1'b0);
    take(tag, exp_res, exp_sat);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_sat", saturated, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // 16 x 0.25 = 4.0 -> 4 * 2^14
    run("quarter", 64'sd16777216, 64'sd16777216, 65536, 0);
    // 16 x 1.0 and 16 x -1.0 clip
    run("pos_sat", 64'sd67108864, 64'sd67108864, 131071, 1);
    run("neg_sat", -64'sd67108864, -64'sd67108864, -131072, 1);

    // Exactly half an output LSB
`ifdef FXP_MAC_CONVERGENT_ROUND_EN
    run("tie_half", 2048, 0, 0, 0);
`else
    run("tie_half", 2048, 0, 1, 0);
`endif
    run("tie_1p5", 6144, 0, 2, 0);
    run("tie_neg", -2048, 0, 0, 0);

    // Back-pressure: result held, extra beat offered but not taken
    out_ready = 1'b0;
    drive_beats(16, 64'sd16777216);
    wait_valid(1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 65536);
      check("bp_sat", saturated, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_count", count, 16);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", out_valid, 0);
    check("bp_count0", count, 0);
    run("bp_next", 64'sd16777216, 64'sd16777216, 65536, 0);

    // clear after 7 beats of 1.0; a beat offered with clear is dropped
    drive_beats(7, 64'sd67108864);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_clear_count", count, 7);
    clear    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_count", count, 0);
    check("clear_in_ready", in_ready, 1);
    run("after_clear", 64'sd16777216, 64'sd16777216, 65536, 0);

    // clear while a result is pending discards it
    out_ready = 1'b0;
    drive_beats(16, 64'sd16777216);
    wait_valid(1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("hold_clear_valid", out_valid, 0);
    check("hold_clear_count", count, 0);
    check("hold_clear_ready", in_ready, 1);
    out_ready = 1'b1;

    // Asynchronous reset mid-accumulation, checked before the next clock edge
    drive_beats(9, 64'sd67108864);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_count", count, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_sat", saturated, 0);
    @(negedge clk);
    rst = 1'b0;
    // 16 x 0.5 = 8.0 exceeds the Q3.14 range
    run("half_sat", 64'sd33554432, 64'sd33554432, 131071, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
